cdc_pulse_arb: RTL and testbench

Source-domain arbiter that shares one cdc_pulse_sync channel among N_REQ event requesters.
- Queues incoming single-cycle events per requester in saturating pending counters.
- Grants requesters round-robin and launches one sync pulse per grant.
- Holds a requester tag stable until the synchronizer's busy handshake completes, so the destination can sample the tag on d_pulse_out.
- Sits between the source event producers and cdc_pulse_sync (s_pulse_in / s_busy).

---
 rtl/cdc_pulse_arb_pkg.sv | 38 +++
 rtl/cdc_pulse_arb_cnt.sv | 41 ++++
 rtl/cdc_pulse_arb.sv | 124 ++++++++++++
 tb/tb_cdc_pulse_arb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pulse_arb_pkg.sv
// Shared types and the round-robin selection helper for the cdc_pulse_arb arbiter.
// Optional feature macro used by the top: CDC_PULSE_ARB_WDOG_EN.
package cdc_pulse_arb_pkg;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req_vec searching upward from ptr+1, wrapping at n_req.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req_vec,
                                         input logic [IDX_W-1:0]   ptr,
                                         input int                 n_req);
        rr_pick_t res;
        int       j;
        res = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n_req && !res.valid) begin
                j = (int'(ptr) + k) % n_req;
                if (req_vec[j]) begin
                    res.valid = 1'b1;
                    res.idx   = IDX_W'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cdc_pulse_arb_cnt.sv
// Saturating pending-event counter for one requester, with a sticky overflow flag.
module cdc_pulse_arb_cnt #(
    parameter int CNT_W = 4
) (
    input  logic s_clk,
    input  logic s_arst_n,
    input  logic inc,
    input  logic dec,
    input  logic ovf_clr,
    output logic nz,
    output logic ovf
);

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             at_max;

    assign at_max = &cnt_q;

    // Simultaneous inc and dec cancel; an event at max with no grant is dropped.
    always_ff @(posedge s_clk or negedge s_arst_n) begin
        if (!s_arst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (inc && !dec && !at_max)
                cnt_q <= cnt_q + 1'b1;
            else if (dec && !inc)
                cnt_q <= cnt_q - 1'b1;

            if (inc && !dec && at_max)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    assign nz  = |cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/cdc_pulse_arb.sv
// Round-robin arbiter sharing one cdc_pulse_sync channel among N_REQ event sources.
// Optional watchdog on the busy handshake: define CDC_PULSE_ARB_WDOG_EN.
module cdc_pulse_arb
    import cdc_pulse_arb_pkg::*;
#(
    parameter  int N_REQ    = 4,
    parameter  int CNT_W    = 4,
    parameter  int WDOG_CYC = 64,
    localparam int TAG_W    = $clog2(N_REQ)
) (
    input  logic             s_clk,
    input  logic             s_arst_n,
    input  logic [N_REQ-1:0] s_req,
    input  logic             s_busy,
    output logic             s_pulse_out,
    output logic [TAG_W-1:0] s_tag_out,
    output logic [N_REQ-1:0] s_pend,
    output logic [N_REQ-1:0] s_ovf,
    input  logic [N_REQ-1:0] s_ovf_clr,
    output logic             s_idle
`ifdef CDC_PULSE_ARB_WDOG_EN
    ,
    output logic             s_wdog_err
`endif
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [TAG_W-1:0]   tag_q;
    logic               pulse_q;
    logic               grant;
    logic [MAX_REQ-1:0] pend_ext;
    logic [N_REQ-1:0]   dec;
    rr_pick_t           pick;

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        assign dec[i] = grant && (pick.idx == IDX_W'(i));

        cdc_pulse_arb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .s_clk    (s_clk),
            .s_arst_n (s_arst_n),
            .inc      (s_req[i]),
            .dec      (dec[i]),
            .ovf_clr  (s_ovf_clr[i]),
            .nz       (s_pend[i]),
            .ovf      (s_ovf[i])
        );
    end

    always_comb begin
        pend_ext              = '0;
        pend_ext[N_REQ-1:0]   = s_pend;
    end

    assign pick = rr_pick(pend_ext, ptr_q, N_REQ);

`ifdef CDC_PULSE_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q;
    logic            wdog_fire;
    logic            wdog_err_q;

    // wdog_q counts cycles already spent waiting; firing on the WDOG_CYC-th one.
    assign wdog_fire = (state_q != IDLE) && (wdog_q == WD_W'(WDOG_CYC - 1));

    always_ff @(posedge s_clk or negedge s_arst_n) begin
        if (!s_arst_n) begin
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (state_d == IDLE || wdog_fire)
                wdog_q <= '0;
            else if (state_q != IDLE)
                wdog_q <= wdog_q + 1'b1;
            if (wdog_fire)
                wdog_err_q <= 1'b1;
        end
    end

    assign s_wdog_err = wdog_err_q;
`endif

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick.valid && !s_busy) begin
                    grant   = 1'b1;
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: if (s_busy)  state_d = WAIT_LO;
            WAIT_LO: if (!s_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef CDC_PULSE_ARB_WDOG_EN
        // A stuck handshake abandons the granted event rather than re-queueing it.
        if (wdog_fire)
            state_d = IDLE;
`endif
    end

    always_ff @(posedge s_clk or negedge s_arst_n) begin
        if (!s_arst_n) begin
            state_q <= IDLE;
            ptr_q   <= IDX_W'(N_REQ - 1);
            tag_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pulse_q <= grant;
            if (grant) begin
                tag_q <= pick.idx[TAG_W-1:0];
                ptr_q <= pick.idx;
            end
        end
    end

    assign s_pulse_out = pulse_q;
    assign s_tag_out   = tag_q;
    assign s_idle      = (state_q == IDLE) && !(|s_pend) && !s_busy;

endmodule

// File: tb/tb_cdc_pulse_arb.sv
// Scoreboard bench for cdc_pulse_arb: directed stimulus queues expected tags,
// a monitor pops them on every launch and emulates the synchronizer's busy.
module tb_cdc_pulse_arb;

    localparam int N_REQ = 4;
    localparam int CNT_W = 2;
    localparam int TAG_W = 2;

    logic             s_clk = 1'b0;
    logic             s_arst_n = 1'b0;
    logic [N_REQ-1:0] s_req = '0;
    logic [N_REQ-1:0] s_ovf_clr = '0;
    logic             s_busy;
    logic             busy_auto = 1'b0;
    logic             busy_hold = 1'b0;
    logic             s_pulse_out;
    logic [TAG_W-1:0] s_tag_out;
    logic [N_REQ-1:0] s_pend;
    logic [N_REQ-1:0] s_ovf;
    logic             s_idle;
`ifdef CDC_PULSE_ARB_WDOG_EN
    logic             s_wdog_err;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int busy_left = 0;
    logic prev_pulse = 1'b0;

    assign s_busy = busy_auto | busy_hold;

    always #5 s_clk = ~s_clk;

    cdc_pulse_arb #(.N_REQ(N_REQ), .CNT_W(CNT_W), .WDOG_CYC(8)) dut (
        .s_clk       (s_clk),
        .s_arst_n    (s_arst_n),
        .s_req       (s_req),
        .s_busy      (s_busy),
        .s_pulse_out (s_pulse_out),
        .s_tag_out   (s_tag_out),
        .s_pend      (s_pend),
        .s_ovf       (s_ovf),
        .s_ovf_clr   (s_ovf_clr),
        .s_idle      (s_idle)
`ifdef CDC_PULSE_ARB_WDOG_EN
        ,
        .s_wdog_err  (s_wdog_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor and busy responder: busy rises on the launch and stays up 3 cycles.
    initial begin
        forever begin
            @(negedge s_clk);
            if (s_pulse_out === 1'b1) begin
                chk("launch_busy_low", {31'd0, s_busy}, 32'd0);
                chk("launch_one_cycle", {31'd0, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch actual_tag=%0d required=none", s_tag_out);
                end else begin
                    chk("launch_tag", {30'd0, s_tag_out}, exp_q.pop_front());
                end
                busy_auto = 1'b1;
                busy_left = 3;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0)
                    busy_auto = 1'b0;
            end
            prev_pulse = s_pulse_out;
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (n < 300 && !(exp_q.size() == 0 && s_idle === 1'b1)) begin
            @(negedge s_clk);
            n++;
        end
        chk(name, {31'd0, (n < 300)}, 32'd1);
        repeat (6) @(negedge s_clk);
        chk({name, "_idle"}, {31'd0, s_idle}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge s_clk);
        #2 s_arst_n = 1'b0;
        @(negedge s_clk);
        #2 s_arst_n = 1'b1;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_pulse", {31'd0, s_pulse_out}, 32'd0);
        chk("rst_tag", {30'd0, s_tag_out}, 32'd0);
        chk("rst_pend", {28'd0, s_pend}, 32'd0);
        chk("rst_ovf", {28'd0, s_ovf}, 32'd0);
        chk("rst_idle", {31'd0, s_idle}, 32'd1);
`ifdef CDC_PULSE_ARB_WDOG_EN
        chk("rst_wdog", {31'd0, s_wdog_err}, 32'd0);
`endif
        @(negedge s_clk);
        #2 s_arst_n = 1'b1;

        // Single event: launch two edges after the request edge, tag 2.
        @(negedge s_clk);
        s_req = 4'b0100;
        exp_q.push_back(2);
        @(negedge s_clk);
        s_req = '0;
        chk("single_no_early", {31'd0, s_pulse_out}, 32'd0);
        chk("single_pend", {28'd0, s_pend}, 32'h4);
        @(negedge s_clk);
        chk("single_pulse", {31'd0, s_pulse_out}, 32'd1);
        chk("single_tag", {30'd0, s_tag_out}, 32'd2);
        wait_drain("single_drain");

        // Round robin from reset: 0,1,2,3 then a lone request 1.
        do_reset();
        @(negedge s_clk);
        s_req = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(k);
        @(negedge s_clk);
        s_req = '0;
        chk("rr_pend_all", {28'd0, s_pend}, 32'hF);
        wait_drain("rr_drain");
        @(negedge s_clk);
        s_req = 4'b0010;
        exp_q.push_back(1);
        @(negedge s_clk);
        s_req = '0;
        wait_drain("rr_next_drain");

        // Burst of 5 events to requester 3.
        for (int k = 0; k < 5; k++) begin
            @(negedge s_clk);
            s_req = 4'b1000;
            exp_q.push_back(3);
            @(negedge s_clk);
            s_req = '0;
            @(negedge s_clk);
        end
        wait_drain("burst_drain");
        chk("burst_no_ovf", {28'd0, s_ovf}, 32'd0);

        // Overflow while busy is held: counter saturates at 3.
        @(negedge s_clk);
        busy_hold = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge s_clk);
            s_req = 4'b0001;
        end
        @(negedge s_clk);
        s_req = '0;
        chk("ovf_flag", {28'd0, s_ovf}, 32'h1);
        chk("ovf_pend", {28'd0, s_pend}, 32'h1);
        chk("ovf_blocked_idle", {31'd0, s_idle}, 32'd0);
        repeat (3) exp_q.push_back(0);
        busy_hold = 1'b0;
        wait_drain("ovf_drain");
        chk("ovf_sticky", {28'd0, s_ovf}, 32'h1);
        @(negedge s_clk);
        s_ovf_clr = 4'b0001;
        @(negedge s_clk);
        s_ovf_clr = '0;
        chk("ovf_cleared", {28'd0, s_ovf}, 32'd0);

        // Request 2 arriving in the grant cycle of 2 is kept for the next round.
        @(negedge s_clk);
        s_req = 4'b0100;
        exp_q.push_back(2);
        @(negedge s_clk);
        exp_q.push_back(2);
        @(negedge s_clk);
        s_req = '0;
        chk("simul_pulse", {31'd0, s_pulse_out}, 32'd1);
        chk("simul_cnt_kept", {28'd0, s_pend}, 32'h4);
        wait_drain("simul_drain");

        // Asynchronous reset during WAIT_LO drops the remaining event.
        @(negedge s_clk);
        s_req = 4'b0110;
        exp_q.push_back(1);
        @(negedge s_clk);
        s_req = '0;
        n = 0;
        while (n < 20 && s_pulse_out !== 1'b1) begin
            @(negedge s_clk);
            n++;
        end
        chk("arst_launch_seen", {31'd0, (n < 20)}, 32'd1);
        @(negedge s_clk);
        #2 s_arst_n = 1'b0;
        #1;
        chk("arst_pulse", {31'd0, s_pulse_out}, 32'd0);
        chk("arst_tag", {30'd0, s_tag_out}, 32'd0);
        chk("arst_pend", {28'd0, s_pend}, 32'd0);
        chk("arst_idle_busy", {31'd0, s_idle}, 32'd0);
        n = 0;
        while (n < 20 && s_busy !== 1'b0) begin
            @(negedge s_clk);
            n++;
        end
        #1;
        chk("arst_idle", {31'd0, s_idle}, 32'd1);
        #1 s_arst_n = 1'b1;
        repeat (15) @(negedge s_clk);
        chk("arst_dropped", {28'd0, s_pend}, 32'd0);
        chk("arst_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
